// File: rtl/kb_ctrl.sv
// PS/2 scan-code sequencer: pops FIFO bytes, tracks held key, modifiers and a BCD press count.
// One byte per 3 cycles (capture, pop strobe, settle); stalls in IDLE while rx_ready is low.
module kb_ctrl #(
    parameter bit CAPS_INIT    = 1'b0,
    parameter bit COUNT_REPEAT = 1'b0
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       rx_overflow,
    output logic       rx_next_n,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_valid,
    output logic       make_pulse,
    output logic       repeat_pulse,
    output logic       break_pulse,
    output logic [7:0] press_count,
    output logic       shift,
    output logic       ctrl,
    output logic       caps,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_POP    = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic ext_pend, brk_pend;
    logic lsh, rsh, caps_held;
    logic capture;
    logic is_e0, is_f0, is_e1;
    logic is_lsh, is_rsh, is_ctl, is_caps, is_mod;
    logic key_match;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (rx_ready) state_nxt = S_POP;
            S_POP:    state_nxt = S_SETTLE;
            S_SETTLE: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rx_next_n = (state != S_POP);
    end

    assign capture   = (state == S_IDLE) && rx_ready;
    assign is_e0     = (rx_data == 8'hE0);
    assign is_f0     = (rx_data == 8'hF0);
    assign is_e1     = (rx_data == 8'hE1);
    assign is_lsh    = (rx_data == 8'h12);
    assign is_rsh    = (rx_data == 8'h59);
    assign is_ctl    = (rx_data == 8'h14);
    // E0 58 is not caps lock, so it falls through as an ordinary key.
    assign is_caps   = (rx_data == 8'h58) && !ext_pend;
    assign is_mod    = is_lsh || is_rsh || is_ctl || is_caps;
    assign key_match = key_valid && (rx_data == key_code) && (ext_pend == key_ext);

    assign shift = lsh || rsh;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] ones, tens;
        ones = v[3:0];
        tens = v[7:4];
        if (ones == 4'd9) begin
            ones = 4'd0;
            tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            key_code     <= 8'h00;
            key_ext      <= 1'b0;
            key_valid    <= 1'b0;
            make_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            break_pulse  <= 1'b0;
            press_count  <= 8'h00;
            lsh          <= 1'b0;
            rsh          <= 1'b0;
            ctrl         <= 1'b0;
            caps         <= CAPS_INIT;
            caps_held    <= 1'b0;
            err          <= 1'b0;
            ext_pend     <= 1'b0;
            brk_pend     <= 1'b0;
        end else begin
            make_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            break_pulse  <= 1'b0;
            if (rx_overflow) err <= 1'b1;
            if (capture) begin
                if (is_e0) begin
                    ext_pend <= 1'b1;
                end else if (is_f0) begin
                    brk_pend <= 1'b1;
                end else if (!is_e1) begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                    if (is_mod) begin
                        if (is_lsh) lsh  <= !brk_pend;
                        if (is_rsh) rsh  <= !brk_pend;
                        if (is_ctl) ctrl <= !brk_pend;
                        if (is_caps) begin
                            // Typematic repeats of caps lock arrive as makes while held.
                            if (!brk_pend) begin
                                caps_held <= 1'b1;
                                if (!caps_held) caps <= !caps;
                            end else begin
                                caps_held <= 1'b0;
                            end
                        end
                    end else if (!brk_pend) begin
                        if (key_match) begin
                            repeat_pulse <= 1'b1;
                            if (COUNT_REPEAT) press_count <= bcd_inc(press_count);
                        end else begin
                            key_code    <= rx_data;
                            key_ext     <= ext_pend;
                            key_valid   <= 1'b1;
                            make_pulse  <= 1'b1;
                            press_count <= bcd_inc(press_count);
                        end
                    end else if (key_match) begin
                        key_valid   <= 1'b0;
                        break_pulse <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
